lut2_reduce_pipe: RTL and testbench

Pipelined, parametrised reduction tree that folds a WIDTH-bit input vector to one bit with a run-time-selected 2-input boolean function. Each tree node is a 2-input LUT built only from 2:1 mux cells and the truth-table constant. This block generalises the mux-built single gate to any 2-input function, any power-of-two width, registered levels and valid/ready flow control. It sits between a data source and any consumer needing parity, all-ones, any-ones or similar reductions.

---
 rtl/lut2_reduce_pkg.sv | 16 +
 rtl/lut2_cell.sv | 21 ++
 rtl/lut2_mux2.sv | 14 +
 rtl/lut2_reduce_pipe.sv | 97 +++++++++
 tb/tb_lut2_reduce_pipe.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lut2_reduce_pkg.sv
// lut2_reduce_pkg: shared types and truth-table constants for the LUT2
// reduction tree.
//   op_t    4-bit truth table, op[{a,b}] = f(a,b)
//   OP_*    common 2-input functions
package lut2_reduce_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_XOR  = 4'b0110;
  localparam op_t OP_XNOR = 4'b1001;
  localparam op_t OP_AND  = 4'b1000;
  localparam op_t OP_OR   = 4'b1110;
  localparam op_t OP_NAND = 4'b0111;
  localparam op_t OP_NOR  = 4'b0001;

endpackage

// File: rtl/lut2_cell.sv
// lut2_cell: combinational 2-input LUT node made of three 2:1 muxes.
//   a, b  node inputs (a is the higher-index operand)
//   op    truth table, y = op[{a,b}]
//   y     node output
module lut2_cell
  import lut2_reduce_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_t  op,
  output logic y
);

  logic lo, hi;

  // b picks within each half of the table, a picks the half
  lut2_mux2 u_lo (.d0(op[0]), .d1(op[1]), .s(b), .y(lo));
  lut2_mux2 u_hi (.d0(op[2]), .d1(op[3]), .s(b), .y(hi));
  lut2_mux2 u_y  (.d0(lo),    .d1(hi),    .s(a), .y(y));

endmodule

// File: rtl/lut2_mux2.sv
// lut2_mux2: single 2:1 mux cell, the only gate the LUT tree is built from.
//   d0, d1  data inputs
//   s       select (1 picks d1)
//   y       output
module lut2_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/lut2_reduce_pipe.sv
// lut2_reduce_pipe: pipelined reduction of a WIDTH-bit vector to one bit
// through a tree of lut2_cell nodes, one register stage per tree level.
// Optional delivered-result counter: define LUT2_REDUCE_PIPE_COUNT_EN.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; in_data vector, in_op truth table
//   out_valid/out_ready   output handshake; out_bit reduced result
//   out_count             delivered-result count (counter build only)
module lut2_reduce_pipe
  import lut2_reduce_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  op_t              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  // op registers only needed for stages that feed another level
  localparam int OPN    = (LEVELS > 1) ? LEVELS - 1 : 1;

  // All node outputs packed level after level: level k (k>=1) has
  // WIDTH>>k bits starting at WIDTH - (2*WIDTH>>k); final bit is WIDTH-2.
  logic [WIDTH-2:0] node_d, node_q;
  logic [LEVELS:1]  vld_q;
  op_t  [OPN:1]     op_q;
  logic             stall, acc;

  assign out_valid = vld_q[LEVELS];
  assign out_bit   = node_q[WIDTH-2];
  // global stall: every stage freezes while the head result waits
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign acc       = in_valid & in_ready;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int OFF = WIDTH - ((2 * WIDTH) >> k);
    localparam int PO  = WIDTH - ((2 * WIDTH) >> (k - 1));
    for (genvar i = 0; i < (WIDTH >> k); i++) begin : g_node
      if (k == 1) begin : g_in
        lut2_cell u_cell (
          .a (in_data[2*i+1]),
          .b (in_data[2*i]),
          .op(in_op),
          .y (node_d[OFF+i])
        );
      end else begin : g_mid
        lut2_cell u_cell (
          .a (node_q[PO+2*i+1]),
          .b (node_q[PO+2*i]),
          .op(op_q[k-1]),
          .y (node_d[OFF+i])
        );
      end
    end
  end

  // Bubbles shift through like beats; only the valid bit distinguishes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q <= '0;
      vld_q  <= '0;
      op_q   <= '0;
    end else if (!stall) begin
      node_q   <= node_d;
      vld_q[1] <= acc;
      for (int k = 2; k <= LEVELS; k++) vld_q[k] <= vld_q[k-1];
      if (LEVELS > 1) begin
        op_q[1] <= in_op;
        for (int k = 2; k <= OPN; k++) op_q[k] <= op_q[k-1];
      end
    end
  end

`ifdef LUT2_REDUCE_PIPE_COUNT_EN
  logic [COUNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (out_valid & out_ready) cnt_q <= cnt_q + COUNT_W'(1);
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_lut2_reduce_pipe.sv
`timescale 1ns/1ps
module tb_lut2_reduce_pipe;
  import lut2_reduce_pkg::*;

  localparam int WIDTH  = 8;
  localparam int LEVELS = 3;

  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_data = '0;
  op_t        in_op = '0;
  logic       in_ready, out_valid, out_bit;
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
  logic [3:0] out_count;
`endif

  lut2_reduce_pipe #(.WIDTH(WIDTH), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit)
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic  exp;
    int    acc;
    bit    lat;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0, delivered = 0, base = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: a handshake completes at the next posedge when both are high
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got out_bit=%0b expected no result", out_bit);
        end else begin
          e = sbq.pop_front();
          chk(e.name, int'(out_bit), int'(e.exp));
          // accepted at edge A -> visible after edge A+LEVELS-1
          if (e.lat) chk({e.name, "_lat"}, cyc - e.acc, LEVELS - 1);
          delivered++;
        end
      end
    end
  end

  // called at posedge+1; leaves in_valid high so the next send is back-to-back
  task automatic send(logic [7:0] d, op_t op, logic e, string nm, bit lat);
    bit   ok = 0;
    int   n  = 0;
    exp_t x;
    in_valid = 1; in_data = d; in_op = op;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk({nm, "_accept_timeout"}, 0, 1);
    else begin
      x.exp = e; x.acc = cyc; x.lat = lat; x.name = nm;
      sbq.push_back(x);
    end
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0, n;
    logic held;

    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bit",   int'(out_bit),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
    chk("rst_out_count", int'(out_count), 0);
`endif
    #20;
    @(posedge clk); #1;
    rst_n = 1;
    base  = delivered;
    wait_cyc(1);

    // isolated beats, latency checked
    send(8'b1011_0011, OP_XOR, 1'b1, "xor_b3", 1); idle(); wait_cyc(4);
    send(8'b1011_0001, OP_XOR, 1'b0, "xor_b1", 1); idle(); wait_cyc(4);

    // back-to-back, op changes every beat
    send(8'hFF,        OP_AND,  1'b1, "and_ff",   1);
    send(8'hFE,        OP_AND,  1'b0, "and_fe",   1);
    send(8'h00,        OP_OR,   1'b0, "or_00",    1);
    send(8'h10,        OP_OR,   1'b1, "or_10",    1);
    send(8'b1000_0000, 4'b0100, 1'b1, "anb_80",   1);
    send(8'b0000_0001, 4'b0100, 1'b0, "anb_01",   1);
    send(8'hFF,        OP_NAND, 1'b0, "nand_ff",  1);
    send(8'h00,        OP_NOR,  1'b1, "nor_00",   1);
    send(8'b1011_0011, OP_XOR,  1'b1, "xor_b3_2", 1);
    idle(); wait_cyc(5);

    // backpressure: 4 stalled cycles in the middle of a 6-beat stream
    d0 = delivered;
    fork
      begin
        send(8'h01, OP_XOR, 1'b1, "bp0", 0);
        send(8'h03, OP_XOR, 1'b0, "bp1", 0);
        send(8'hFF, OP_AND, 1'b1, "bp2", 0);
        send(8'h00, OP_OR,  1'b0, "bp3", 0);
        send(8'h80, OP_OR,  1'b1, "bp4", 0);
        send(8'h07, OP_XOR, 1'b1, "bp5", 0);
        idle();
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        if (!out_valid) chk("bp_first_valid_timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        held = out_bit;
        chk("bp_held_is_head", int'(out_bit), (sbq.size() > 0) ? int'(sbq[0].exp) : -1);
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_in_ready",  int'(in_ready),  0);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_out_bit",   int'(out_bit),   int'(held));
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
          chk("bp_count_hold", int'(out_count), (delivered - base) & 15);
`endif
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    chk("bp_delivered", delivered - d0, 6);

    // async reset with beats in flight
    wait_cyc(2);
    send(8'h01, OP_XOR, 1'b1, "st0", 0);
    send(8'h02, OP_XOR, 1'b1, "st1", 0);
    send(8'h03, OP_XOR, 1'b0, "st2", 0);
    idle();
    #2;
    rst_n = 0;
    sbq.delete();
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_bit",   int'(out_bit),   0);
    chk("arst_in_ready",  int'(in_ready),  1);
`ifdef LUT2_REDUCE_PIPE_COUNT_EN
    chk("arst_out_count", int'(out_count), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    base  = delivered;
    wait_cyc(5);
    send(8'b1011_0011, OP_XOR, 1'b1, "post_rst", 1); idle(); wait_cyc(5);

`ifdef LUT2_REDUCE_PIPE_COUNT_EN
    // 1 result so far since reset; 16 more wraps a 4-bit counter to 1
    for (int i = 0; i < 16; i++) send(8'h00, OP_XOR, 1'b0, "cnt_beat", 1);
    idle(); wait_cyc(6);
    chk("count_wrap", int'(out_count), 1);
`endif

    n = 0;
    while (sbq.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
